tlu_handshake_mc: RTL and testbench

Parametrised successor to the TLU slave core. It runs the EUDET/AIDA TLU handshake in one of three selectable modes, with a configurable trigger-ID width. It collects trigger acknowledges from up to NUM_ACK downstream DUT channels under a mask, and buffers trigger words in an internal show-ahead FIFO of configurable depth. It sits between the TLU connector pins and the 32-bit readout arbiter, and is configured by static inputs driven from the register file.

---
 rtl/tlu_mc_pkg.sv | 28 ++
 rtl/tlu_word_fifo.sv | 55 +++++
 rtl/tlu_handshake_mc.sv | 195 +++++++++++++++++++
 tb/tb_tlu_handshake_mc.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_mc_pkg.sv
// Shared types and constants for the multi-mode TLU handshake core.
package tlu_mc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBusy,
    StShift,
    StPush,
    StWaitAck,
    StRelease
  } tlu_state_e;

  localparam logic [1:0] MODE_TRIGGER_ONLY = 2'd0;
  localparam logic [1:0] MODE_BUSY         = 2'd1;
  localparam logic [1:0] MODE_DATA         = 2'd2;

  localparam int unsigned HEADER_BIT = 31;

  // The reserved encoding 3 behaves as trigger-only.
  function automatic logic [1:0] decode_mode(input logic [1:0] raw);
    case (raw)
      MODE_BUSY: return MODE_BUSY;
      MODE_DATA: return MODE_DATA;
      default:   return MODE_TRIGGER_ONLY;
    endcase
  endfunction

endpackage

// File: rtl/tlu_word_fifo.sv
// Show-ahead single-clock 32-bit word FIFO; a pop in the same cycle frees room for a push when full.
module tlu_word_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tlu_handshake_mc.sv
// Multi-mode EUDET/AIDA TLU handshake core with masked acknowledge collection and a trigger FIFO.
// Define ACK_TIMEOUT_EN to build the acknowledge timeout and its TIMEOUT_CNT counter.
module tlu_handshake_mc
  import tlu_mc_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 15,
  parameter int unsigned DIVISOR  = 8,
  parameter int unsigned NUM_ACK  = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic               TRIGGER_CLK,
  input  logic               RST_N,
  input  logic               CONF_EN,
  input  logic [1:0]         CONF_MODE,
  input  logic [NUM_ACK-1:0] CONF_ACK_MASK,
  input  logic               TLU_TRIGGER,
  output logic               TLU_BUSY,
  output logic               TLU_CLOCK,
  output logic               TRIGGER_ACCEPTED,
  input  logic [NUM_ACK-1:0] ACK,
  input  logic               FIFO_READ,
  output logic               FIFO_EMPTY,
  output logic [31:0]        FIFO_DATA,
  output logic [7:0]         LOST_CNT,
  output logic [7:0]         TIMEOUT_CNT
);

  if (ID_WIDTH < 1 || ID_WIDTH > 31 || DIVISOR < 2 || NUM_ACK < 1 || TIMEOUT < 1 ||
      DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("tlu_handshake_mc: illegal parameter value");
  end

  localparam int unsigned DivW = $clog2(2 * DIVISOR);
  localparam int unsigned BitW = $clog2(ID_WIDTH + 1);

  tlu_state_e          state_q, state_d;
  logic                trg_meta_q, trg_q, trg_prev_q;
  logic [1:0]          mode_q, mode_in;
  logic [NUM_ACK-1:0]  mask_q;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ID_WIDTH-1:0] shift_q, shift_d, id_cnt_q;
  logic                busy_d, clock_d, accepted_d;
  logic                trg_rise, ack_ok, period_end, shift_last, push, timeout_hit;
  logic                fifo_full;
  logic [31:0]         word;
  logic [7:0]          lost_q;

  assign mode_in    = decode_mode(CONF_MODE);
  assign trg_rise   = trg_q && !trg_prev_q;
  assign ack_ok     = ((ACK & mask_q) == mask_q);
  assign period_end = (div_cnt_q == DivW'(2 * DIVISOR - 1));
  assign shift_last = period_end && (bit_cnt_q == BitW'(ID_WIDTH));
  assign push       = (state_q == StPush) && CONF_EN;

  always_ff @(posedge TRIGGER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (trg_rise) begin
          state_d = (mode_in == MODE_TRIGGER_ONLY) ? StPush : StBusy;
        end
      end
      StBusy:    state_d = (mode_q == MODE_DATA) ? StShift : StPush;
      StShift:   if (shift_last) state_d = StPush;
      StPush:    state_d = (mode_q == MODE_TRIGGER_ONLY) ? StIdle : StWaitAck;
      StWaitAck: if (ack_ok || timeout_hit) state_d = StRelease;
      StRelease: if (!trg_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // Disabling aborts any handshake in flight; the FIFO is untouched.
    if (!CONF_EN) begin
      state_d = StIdle;
    end
  end

  // Shift clock period counters; TRG is captured in the last low cycle of each data period.
  always_comb begin
    div_cnt_d = '0;
    bit_cnt_d = '0;
    shift_d   = shift_q;
    if (state_q == StShift) begin
      div_cnt_d = period_end ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d = period_end ? bit_cnt_q + 1'b1 : bit_cnt_q;
      if (period_end && bit_cnt_q != '0) begin
        shift_d               = shift_q >> 1;
        shift_d[ID_WIDTH-1]   = trg_q;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d     = (state_d == StBusy) || (state_d == StShift) || (state_d == StWaitAck) ||
                 ((state_d == StPush) && (state_q != StIdle));
    clock_d    = (state_d == StShift) && (div_cnt_d < DivW'(DIVISOR));
    accepted_d = (state_q == StIdle) && (state_d != StIdle);
  end

  always_comb begin
    word                 = '0;
    word[HEADER_BIT]     = 1'b1;
    word[ID_WIDTH-1:0]   = (mode_q == MODE_DATA) ? shift_q : id_cnt_q;
  end

  always_ff @(posedge TRIGGER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      trg_meta_q       <= 1'b0;
      trg_q            <= 1'b0;
      trg_prev_q       <= 1'b0;
      mode_q           <= MODE_TRIGGER_ONLY;
      mask_q           <= '0;
      div_cnt_q        <= '0;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      id_cnt_q         <= '0;
      TLU_BUSY         <= 1'b0;
      TLU_CLOCK        <= 1'b0;
      TRIGGER_ACCEPTED <= 1'b0;
      lost_q           <= '0;
    end else begin
      trg_meta_q       <= TLU_TRIGGER;
      trg_q            <= trg_meta_q;
      trg_prev_q       <= trg_q;
      div_cnt_q        <= div_cnt_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      TLU_BUSY         <= busy_d;
      TLU_CLOCK        <= clock_d;
      TRIGGER_ACCEPTED <= accepted_d;
      if (state_q == StIdle) begin
        mode_q <= mode_in;
        mask_q <= CONF_ACK_MASK;
      end
      if (push) begin
        id_cnt_q <= (mode_q == MODE_DATA) ? shift_q + 1'b1 : id_cnt_q + 1'b1;
      end
      // Full FIFO drops the word unless a pop frees a slot this cycle.
      if (push && fifo_full && !FIFO_READ && lost_q != 8'hFF) begin
        lost_q <= lost_q + 1'b1;
      end
    end
  end

  assign LOST_CNT = lost_q;

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] to_cnt_q;
  logic [7:0]     timeout_cnt_q;

  assign timeout_hit = (state_q == StWaitAck) && !ack_ok && (to_cnt_q == ToW'(TIMEOUT - 1));

  always_ff @(posedge TRIGGER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt_q      <= '0;
      timeout_cnt_q <= '0;
    end else begin
      to_cnt_q <= (state_q == StWaitAck) ? to_cnt_q + 1'b1 : '0;
      if (timeout_hit && CONF_EN && timeout_cnt_q != 8'hFF) begin
        timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end
    end
  end

  assign TIMEOUT_CNT = timeout_cnt_q;
`else
  assign timeout_hit = 1'b0;
  assign TIMEOUT_CNT = '0;
`endif

  tlu_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (TRIGGER_CLK),
    .rst_n(RST_N),
    .push (push),
    .wdata(word),
    .pop  (FIFO_READ),
    .rdata(FIFO_DATA),
    .full (fifo_full),
    .empty(FIFO_EMPTY)
  );

endmodule

// File: tb/tb_tlu_handshake_mc.sv
// Self-checking bench for tlu_handshake_mc against a transaction-level model of trigger words.
module tb_tlu_handshake_mc;

  localparam int unsigned IdW  = 15;
  localparam int unsigned Div  = 4;
  localparam int unsigned NAck = 4;
  localparam int unsigned Dep  = 4;
  localparam int unsigned Tmo  = 100;

  logic            TRIGGER_CLK = 1'b0;
  logic            RST_N;
  logic            CONF_EN;
  logic [1:0]      CONF_MODE;
  logic [NAck-1:0] CONF_ACK_MASK;
  logic            TLU_TRIGGER;
  logic            TLU_BUSY;
  logic            TLU_CLOCK;
  logic            TRIGGER_ACCEPTED;
  logic [NAck-1:0] ACK;
  logic            FIFO_READ;
  logic            FIFO_EMPTY;
  logic [31:0]     FIFO_DATA;
  logic [7:0]      LOST_CNT;
  logic [7:0]      TIMEOUT_CNT;

  always #5 TRIGGER_CLK = ~TRIGGER_CLK;

  tlu_handshake_mc #(
    .ID_WIDTH(IdW),
    .DIVISOR (Div),
    .NUM_ACK (NAck),
    .DEPTH   (Dep),
    .TIMEOUT (Tmo)
  ) dut (
    .TRIGGER_CLK     (TRIGGER_CLK),
    .RST_N           (RST_N),
    .CONF_EN         (CONF_EN),
    .CONF_MODE       (CONF_MODE),
    .CONF_ACK_MASK   (CONF_ACK_MASK),
    .TLU_TRIGGER     (TLU_TRIGGER),
    .TLU_BUSY        (TLU_BUSY),
    .TLU_CLOCK       (TLU_CLOCK),
    .TRIGGER_ACCEPTED(TRIGGER_ACCEPTED),
    .ACK             (ACK),
    .FIFO_READ       (FIFO_READ),
    .FIFO_EMPTY      (FIFO_EMPTY),
    .FIFO_DATA       (FIFO_DATA),
    .LOST_CNT        (LOST_CNT),
    .TIMEOUT_CNT     (TIMEOUT_CNT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor counts, only ever written here; tests compare snapshots.
  int acc_cnt   = 0;
  int busy_cyc  = 0;
  always @(negedge TRIGGER_CLK) begin
    if (TRIGGER_ACCEPTED === 1'b1) acc_cnt++;
    if (TLU_BUSY === 1'b1) busy_cyc++;
  end

  // Reference model: queue of expected words, next internal ID, dropped-word count.
  logic [31:0] exp_q[$];
  int          model_id   = 0;
  int          model_lost = 0;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge TRIGGER_CLK);
    #1;
  endtask

  task automatic model_push(input int id);
    logic [31:0] w;
    w = 32'h8000_0000 | (id & 32'h7FFF);
    if (exp_q.size() < Dep) exp_q.push_back(w);
    else if (model_lost < 255) model_lost++;
  endtask

  task automatic pop_check(input string name);
    int k = 0;
    while (FIFO_EMPTY === 1'b1 && k < 50) begin
      cyc();
      k++;
    end
    n_checks++;
    if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== exp_q[0]) begin
      n_fail++;
      $display("FAIL %s: got data %h empty %b, expected data %h empty 0", name, FIFO_DATA,
               FIFO_EMPTY, exp_q[0]);
    end
    FIFO_READ = 1'b1;
    cyc();
    FIFO_READ = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) pop_check(name);
    n_checks++;
    if (FIFO_EMPTY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_empty: got %b expected 1", name, FIFO_EMPTY);
    end
  endtask

  task automatic trig_simple(input logic [1:0] mode);
    CONF_MODE   = mode;
    TLU_TRIGGER = 1'b1;
    cyc($urandom_range(2, 4));
    TLU_TRIGGER = 1'b0;
    cyc(4);
    model_push(model_id);
    model_id = (model_id + 1) & 32'h7FFF;
  endtask

  task automatic trig_busy(input logic [NAck-1:0] mask, input string name);
    int k = 0;
    CONF_MODE     = 2'd1;
    CONF_ACK_MASK = mask;
    ACK           = '0;
    TLU_TRIGGER   = 1'b1;
    while (TRIGGER_ACCEPTED !== 1'b1 && k < 10) begin
      cyc();
      k++;
    end
    n_checks++;
    if (k != 3 || TLU_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: accepted after %0d cycles busy %b, expected 3 cycles busy 1",
               name, k, TLU_BUSY);
    end
    cyc();
    n_checks++;
    if (TRIGGER_ACCEPTED !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: accepted %b on 2nd cycle, expected 0", name, TRIGGER_ACCEPTED);
    end
    cyc($urandom_range(1, 6));
    ACK = mask | NAck'($urandom);
    k = 0;
    while (TLU_BUSY !== 1'b0 && k < 10) begin
      cyc();
      k++;
    end
    n_checks++;
    if (TLU_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: busy %b after ack, expected 0", name, TLU_BUSY);
    end
    TLU_TRIGGER = 1'b0;
    cyc(4);
    ACK = '0;
    model_push(model_id);
    model_id = (model_id + 1) & 32'h7FFF;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CONF_EN = 1'b1; CONF_MODE = 2'd0; CONF_ACK_MASK = '0;
    TLU_TRIGGER = 1'b0; ACK = '0; FIFO_READ = 1'b0;
    cyc(3);
    n_checks++;
    if ({TLU_BUSY, TLU_CLOCK, TRIGGER_ACCEPTED} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy/clk/acc %b expected 000",
               {TLU_BUSY, TLU_CLOCK, TRIGGER_ACCEPTED});
    end
    n_checks++;
    if (FIFO_EMPTY !== 1'b1 || FIFO_DATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fifo: got empty %b data %h expected 1 00000000", FIFO_EMPTY, FIFO_DATA);
    end
    n_checks++;
    if (LOST_CNT !== 8'd0 || TIMEOUT_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got lost %0d timeout %0d expected 0 0", LOST_CNT, TIMEOUT_CNT);
    end
    RST_N = 1'b1;
    cyc(2);
  endtask

  task automatic test_trigger_only();
    int a0 = acc_cnt;
    int b0 = busy_cyc;
    for (int i = 0; i < 5; i++) begin
      trig_simple(2'd0);
      pop_check("trigger_only_word");
    end
    n_checks++;
    if (acc_cnt - a0 != 5 || busy_cyc != b0) begin
      n_fail++;
      $display("FAIL trigger_only_pulses: got %0d accepted %0d busy cycles expected 5 and 0",
               acc_cnt - a0, busy_cyc - b0);
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 6; i++) trig_simple(2'd0);
    n_checks++;
    if (LOST_CNT !== 8'(model_lost) || FIFO_EMPTY !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full_lost: got lost %0d empty %b expected lost %0d empty 0",
               LOST_CNT, FIFO_EMPTY, model_lost);
    end
    drain("fifo_full_word");
  endtask

  task automatic test_data_mode(input logic [IdW-1:0] rx_id, input string name);
    int  n = 0, first = -1, rises = 0, high = 0, done = -1;
    logic prev = 1'b0;
    CONF_MODE = 2'd2; CONF_ACK_MASK = 4'b0011; ACK = '0;
    TLU_TRIGGER = 1'b1;
    while (FIFO_EMPTY === 1'b1 && n < 400) begin
      cyc();
      n++;
      if (TLU_CLOCK === 1'b1 && !prev) begin
        rises++;
        if (rises == 1) first = n;
        if (rises >= 2 && rises <= 16) TLU_TRIGGER = rx_id[rises-2];
      end
      if (TLU_CLOCK === 1'b1) high++;
      prev = TLU_CLOCK;
    end
    if (FIFO_EMPTY === 1'b0) done = n;
    n_checks++;
    if (rises != 16 || high != 16 * Div) begin
      n_fail++;
      $display("FAIL %s_clock: got %0d periods %0d high cycles expected 16 and %0d", name, rises,
               high, 16 * Div);
    end
    n_checks++;
    if (done - first != 2 * Div * 16 + 1 || TLU_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_shift_len: got %0d cycles busy %b expected %0d busy 1", name,
               done - first, TLU_BUSY, 2 * Div * 16 + 1);
    end
    TLU_TRIGGER = 1'b1;
    cyc(10);
    ACK = 4'b0001;
    cyc(3);
    n_checks++;
    if (TLU_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_partial_ack: got busy %b expected 1", name, TLU_BUSY);
    end
    ACK = 4'b0011 | {2'($urandom), 2'b00};
    cyc();
    n_checks++;
    if (TLU_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: got busy %b expected 0 while trigger high", name, TLU_BUSY);
    end
    cyc(2);
    TLU_TRIGGER = 1'b0;
    cyc(4);
    ACK = '0;
    model_push(int'(rx_id));
    model_id = (int'(rx_id) + 1) & 32'h7FFF;
    pop_check({name, "_word"});
  endtask

  task automatic test_busy_mode();
    for (int i = 0; i < 4; i++) begin
      trig_busy(NAck'($urandom), "busy_mode");
      pop_check("busy_mode_word");
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    CONF_MODE = 2'd1; CONF_ACK_MASK = 4'b1000; ACK = '0;
    TLU_TRIGGER = 1'b1;
    while (TRIGGER_ACCEPTED !== 1'b1 && k < 10) begin
      cyc();
      k++;
    end
`ifdef ACK_TIMEOUT_EN
    k = 0;
    while (TLU_BUSY !== 1'b0 && k < 300) begin
      cyc();
      k++;
    end
    n_checks++;
    if (k != Tmo + 2 || TIMEOUT_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL timeout_release: got %0d cycles count %0d expected %0d cycles count 1", k,
               TIMEOUT_CNT, Tmo + 2);
    end
`else
    cyc(200);
    n_checks++;
    if (TLU_BUSY !== 1'b1 || TIMEOUT_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout_hold: got busy %b count %0d expected busy 1 count 0", TLU_BUSY,
               TIMEOUT_CNT);
    end
    ACK = 4'b1000;
    cyc();
    n_checks++;
    if (TLU_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_late_ack: got busy %b expected 0", TLU_BUSY);
    end
`endif
    TLU_TRIGGER = 1'b0;
    cyc(4);
    ACK = '0;
    model_push(model_id);
    model_id = (model_id + 1) & 32'h7FFF;
    pop_check("timeout_word");
  endtask

  task automatic test_conf_en_drop();
    int k = 0;
    int a0;
    CONF_MODE = 2'd2; CONF_ACK_MASK = 4'b0001; ACK = '0;
    TLU_TRIGGER = 1'b1;
    while (TLU_CLOCK !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    cyc($urandom_range(5, 60));
    CONF_EN = 1'b0;
    cyc();
    n_checks++;
    if (TLU_BUSY !== 1'b0 || TLU_CLOCK !== 1'b0) begin
      n_fail++;
      $display("FAIL conf_en_abort: got busy %b clock %b expected 0 0", TLU_BUSY, TLU_CLOCK);
    end
    TLU_TRIGGER = 1'b0;
    cyc(4);
    a0 = acc_cnt;
    TLU_TRIGGER = 1'b1;
    cyc(3);
    TLU_TRIGGER = 1'b0;
    cyc(15);
    n_checks++;
    if (FIFO_EMPTY !== 1'b1 || acc_cnt != a0) begin
      n_fail++;
      $display("FAIL conf_en_idle: got empty %b accepted %0d expected empty 1 accepted 0",
               FIFO_EMPTY, acc_cnt - a0);
    end
    CONF_EN = 1'b1;
    cyc(2);
    trig_busy(4'b0110, "conf_en_next");
    pop_check("conf_en_next_word");
  endtask

  task automatic test_back_to_back();
    int a0 = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0:       trig_simple(2'd0);
        1:       trig_busy(NAck'($urandom), "b2b");
        default: trig_simple(2'd3);
      endcase
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_check("b2b_word");
    end
    n_checks++;
    if (acc_cnt - a0 != 12 || LOST_CNT !== 8'(model_lost)) begin
      n_fail++;
      $display("FAIL b2b_counts: got %0d accepted lost %0d expected 12 lost %0d", acc_cnt - a0,
               LOST_CNT, model_lost);
    end
    drain("b2b_drain");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    trig_simple(2'd0);
    trig_simple(2'd0);
    CONF_MODE = 2'd1; CONF_ACK_MASK = 4'b0001; ACK = '0;
    TLU_TRIGGER = 1'b1;
    while (TRIGGER_ACCEPTED !== 1'b1 && k < 10) begin
      cyc();
      k++;
    end
    cyc(4);
    n_checks++;
    if (TLU_BUSY !== 1'b1 || FIFO_EMPTY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got busy %b empty %b expected 1 0", TLU_BUSY, FIFO_EMPTY);
    end
    RST_N = 1'b0;
    #2;
    n_checks++;
    if ({TLU_BUSY, TLU_CLOCK, TRIGGER_ACCEPTED, FIFO_EMPTY} !== 4'b0001 ||
        FIFO_DATA !== 32'h0 || LOST_CNT !== 8'd0 || TIMEOUT_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy %b clk %b acc %b empty %b data %h lost %0d to %0d",
               TLU_BUSY, TLU_CLOCK, TRIGGER_ACCEPTED, FIFO_EMPTY, FIFO_DATA, LOST_CNT,
               TIMEOUT_CNT);
    end
    exp_q.delete();
    model_id   = 0;
    model_lost = 0;
    TLU_TRIGGER = 1'b0;
    cyc(2);
    RST_N = 1'b1;
    cyc(3);
    trig_simple(2'd0);
    pop_check("reset_mid_after");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_trigger_only();
    test_fifo_full();
    test_data_mode(15'h1234, "data_fixed");
    test_data_mode(IdW'($urandom), "data_rand");
    test_busy_mode();
    test_timeout();
    test_conf_en_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
